// File: rtl/power_sequencer.sv
// Power-domain sequencer: isolate -> save -> power-off, and power-up -> restore -> de-isolate.
// Latency: sleep takes ISO_CYCLES+SAVE_CYCLES edges, wake takes PWRUP_CYCLES+RESTORE_CYCLES edges; all outputs registered.
// Backpressure: none; requests are levels sampled every edge, wake_req aborts a power-down in ISOLATE/SAVE.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   sleep_req, wake_req level requests from the system power manager
//   power_en, iso_en    domain switch enable, isolation clamp enable
//   save, restore       retention strobes (levels)
//   sleep_ack, wake_ack one-cycle pulses on entering OFF / returning to ACTIVE
//   state_o, busy       current state code, high outside ACTIVE and OFF
module power_sequencer #(
    parameter int ISO_CYCLES     = 2,
    parameter int SAVE_CYCLES    = 2,
    parameter int PWRUP_CYCLES   = 4,
    parameter int RESTORE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep_req,
    input  logic       wake_req,
    output logic       power_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       sleep_ack,
    output logic       wake_ack,
    output logic [2:0] state_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_ACTIVE   = 3'd0,
        ST_ISOLATE  = 3'd1,
        ST_SAVE     = 3'd2,
        ST_OFF      = 3'd3,
        ST_POWER_UP = 3'd4,
        ST_RESTORE  = 3'd5
    } state_t;

    // Counter reload values: a phase of N cycles starts at N-1 and exits at 0.
    localparam logic [3:0] ISO_LOAD     = 4'(ISO_CYCLES - 1);
    localparam logic [3:0] SAVE_LOAD    = 4'(SAVE_CYCLES - 1);
    localparam logic [3:0] PWRUP_LOAD   = 4'(PWRUP_CYCLES - 1);
    localparam logic [3:0] RESTORE_LOAD = 4'(RESTORE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       expired;

    logic power_en_nxt;
    logic iso_en_nxt;
    logic save_nxt;
    logic restore_nxt;
    logic sleep_ack_nxt;
    logic wake_ack_nxt;
    logic busy_nxt;

    assign expired = (cnt == 4'd0);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE:   if (sleep_req && !wake_req) state_nxt = ST_ISOLATE;
            // Abort beats expiry: power has not been removed yet.
            ST_ISOLATE:  if (wake_req) state_nxt = ST_ACTIVE;
                         else if (expired) state_nxt = ST_SAVE;
            ST_SAVE:     if (wake_req) state_nxt = ST_ACTIVE;
                         else if (expired) state_nxt = ST_OFF;
            ST_OFF:      if (wake_req) state_nxt = ST_POWER_UP;
            ST_POWER_UP: if (expired) state_nxt = ST_RESTORE;
            ST_RESTORE:  if (expired) state_nxt = ST_ACTIVE;
            default:     state_nxt = ST_ACTIVE;
        endcase
    end

    // Shared phase counter: reload on state entry, otherwise count down to 0.
    always_comb begin
        cnt_nxt = expired ? 4'd0 : cnt - 4'd1;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_ISOLATE:  cnt_nxt = ISO_LOAD;
                ST_SAVE:     cnt_nxt = SAVE_LOAD;
                ST_POWER_UP: cnt_nxt = PWRUP_LOAD;
                ST_RESTORE:  cnt_nxt = RESTORE_LOAD;
                default:     cnt_nxt = 4'd0;
            endcase
        end
    end

    // Output decode from the next state so outputs move with state_o.
    always_comb begin
        power_en_nxt = 1'b1;
        iso_en_nxt   = 1'b1;
        save_nxt     = 1'b0;
        restore_nxt  = 1'b0;
        busy_nxt     = 1'b1;
        case (state_nxt)
            ST_ACTIVE: begin
                iso_en_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
            ST_SAVE:    save_nxt = 1'b1;
            ST_OFF: begin
                power_en_nxt = 1'b0;
                busy_nxt     = 1'b0;
            end
            ST_RESTORE: restore_nxt = 1'b1;
            default: ;
        endcase
        sleep_ack_nxt = (state_nxt == ST_OFF) && (state != ST_OFF);
        // ACTIVE is only re-entered from RESTORE or an abort, both acknowledged.
        wake_ack_nxt  = (state_nxt == ST_ACTIVE) && (state != ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACTIVE;
            cnt       <= 4'd0;
            power_en  <= 1'b1;
            iso_en    <= 1'b0;
            save      <= 1'b0;
            restore   <= 1'b0;
            sleep_ack <= 1'b0;
            wake_ack  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            power_en  <= power_en_nxt;
            iso_en    <= iso_en_nxt;
            save      <= save_nxt;
            restore   <= restore_nxt;
            sleep_ack <= sleep_ack_nxt;
            wake_ack  <= wake_ack_nxt;
            busy      <= busy_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_power_sequencer.sv
module tb_power_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic sleep_req;
    logic wake_req;

    logic       pe0, iso0, sv0, rs0, sa0, wa0, bz0;
    logic [2:0] st0;
    logic       pe1, iso1, sv1, rs1, sa1, wa1, bz1;
    logic [2:0] st1;

    always #5 clk = ~clk;

    power_sequencer u_dflt (
        .clk(clk), .rst(rst), .sleep_req(sleep_req), .wake_req(wake_req),
        .power_en(pe0), .iso_en(iso0), .save(sv0), .restore(rs0),
        .sleep_ack(sa0), .wake_ack(wa0), .state_o(st0), .busy(bz0)
    );

    power_sequencer #(
        .ISO_CYCLES(1), .SAVE_CYCLES(15), .PWRUP_CYCLES(8), .RESTORE_CYCLES(1)
    ) u_sweep (
        .clk(clk), .rst(rst), .sleep_req(sleep_req), .wake_req(wake_req),
        .power_en(pe1), .iso_en(iso1), .save(sv1), .restore(rs1),
        .sleep_ack(sa1), .wake_ack(wa1), .state_o(st1), .busy(bz1)
    );

    // Reference model: phase name plus cycles spent in it.
    localparam int P_ACT = 0, P_ISO = 1, P_SAVE = 2, P_OFF = 3, P_PUP = 4, P_RST = 5;

    int ph[2];
    int n[2];
    logic [9:0] q[2][$];
    int checks = 0;
    int errors = 0;
    int since_pe_rise[2];

    function automatic int plen(input int k, input int p);
        int l;
        l = 0;
        case (p)
            P_ISO:  l = (k == 0) ? 2 : 1;
            P_SAVE: l = (k == 0) ? 2 : 15;
            P_PUP:  l = (k == 0) ? 4 : 8;
            P_RST:  l = (k == 0) ? 2 : 1;
            default: l = 0;
        endcase
        return l;
    endfunction

    // Expected vector {power_en, iso_en, save, restore, sleep_ack, wake_ack, busy, state[2:0]}
    task automatic model_step(input int k, input logic s, input logic w, input logic r);
        int prev;
        int nxt;
        logic [9:0] e;
        prev = ph[k];
        nxt  = prev;
        if (r) begin
            ph[k] = P_ACT;
            n[k]  = 0;
            e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
            q[k].push_back(e);
            return;
        end
        case (prev)
            P_ACT:  if (s && !w) nxt = P_ISO;
            P_ISO:  if (w) nxt = P_ACT; else if (n[k] >= plen(k, prev)) nxt = P_SAVE;
            P_SAVE: if (w) nxt = P_ACT; else if (n[k] >= plen(k, prev)) nxt = P_OFF;
            P_OFF:  if (w) nxt = P_PUP;
            P_PUP:  if (n[k] >= plen(k, prev)) nxt = P_RST;
            P_RST:  if (n[k] >= plen(k, prev)) nxt = P_ACT;
            default: nxt = P_ACT;
        endcase
        if (nxt != prev) n[k] = 1;
        else n[k] = n[k] + 1;
        ph[k] = nxt;
        e[9] = (nxt != P_OFF);
        e[8] = (nxt != P_ACT);
        e[7] = (nxt == P_SAVE);
        e[6] = (nxt == P_RST);
        e[5] = (nxt == P_OFF) && (prev != P_OFF);
        e[4] = (nxt == P_ACT) && (prev != P_ACT);
        e[3] = (nxt != P_ACT) && (nxt != P_OFF);
        e[2:0] = 3'(nxt);
        q[k].push_back(e);
    endtask

    // Drive one cycle of inputs; the models see the same values the DUTs sample.
    task automatic cyc(input logic s, input logic w, input logic r);
        sleep_req = s;
        wake_req  = w;
        rst       = r;
        @(posedge clk);
        model_step(0, s, w, r);
        model_step(1, s, w, r);
        #1;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected vector per DUT per edge, compared away from the edge.
    logic [9:0] act[2];
    logic [9:0] prev_act[2];
    logic       have_prev[2];
    initial begin
        have_prev[0] = 1'b0;
        have_prev[1] = 1'b0;
        since_pe_rise[0] = 100;
        since_pe_rise[1] = 100;
    end

    always @(negedge clk) begin
        logic [9:0] e;
        act[0] = {pe0, iso0, sv0, rs0, sa0, wa0, bz0, st0};
        act[1] = {pe1, iso1, sv1, rs1, sa1, wa1, bz1, st1};
        for (int k = 0; k < 2; k++) begin
            if (q[k].size() > 0) begin
                e = q[k].pop_front();
                checks++;
                if (act[k] !== e) begin
                    errors++;
                    $display("FAIL outputs dut%0d t=%0t actual=%b required=%b", k, $time, act[k], e);
                end
                checks++;
                if (!(act[k][8] || act[k][9])) begin
                    errors++;
                    $display("FAIL iso_when_off dut%0d t=%0t actual iso_en=%b power_en=%b required iso_en=1",
                             k, $time, act[k][8], act[k][9]);
                end
                if (have_prev[k] && prev_act[k][9] && !act[k][9]) begin
                    checks++;
                    if (!prev_act[k][7]) begin
                        errors++;
                        $display("FAIL save_before_off dut%0d t=%0t actual prev save=%b required 1",
                                 k, $time, prev_act[k][7]);
                    end
                end
                // restore must follow a power_en rise within 10 cycles
                if (have_prev[k] && !prev_act[k][9] && act[k][9]) since_pe_rise[k] = 0;
                else if (since_pe_rise[k] < 100) since_pe_rise[k]++;
                if (act[k][6] && since_pe_rise[k] < 100) begin
                    checks++;
                    if (since_pe_rise[k] > 10) begin
                        errors++;
                        $display("FAIL restore_window dut%0d t=%0t actual=%0d required<=10",
                                 k, $time, since_pe_rise[k]);
                    end
                    since_pe_rise[k] = 100;
                end
                prev_act[k]  = act[k];
                have_prev[k] = 1'b1;
            end
        end
    end

    initial begin
        int s_pct, w_pct, len;
        ph[0] = P_ACT; ph[1] = P_ACT;
        n[0] = 0; n[1] = 0;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        rst       = 1'b1;

        // Reset then idle
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        idle(20);

        // Full sleep/wake on single-cycle pulses
        cyc(1, 0, 0);
        idle(25);
        cyc(0, 1, 0);
        idle(25);

        // Abort on first SAVE cycle (defaults: SAVE entered 2 edges after sleep)
        cyc(1, 0, 0);
        idle(2);
        cyc(0, 1, 0);
        idle(5);
        // Abort on the final SAVE count edge
        cyc(1, 0, 0);
        idle(3);
        cyc(0, 1, 0);
        idle(20);

        // Both requests in ACTIVE
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);

        // Reset while OFF and while in RESTORE
        cyc(1, 0, 0);
        idle(20);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(20);
        cyc(0, 1, 0);
        idle(4);
        cyc(0, 0, 1);
        idle(5);

        // sleep_req held through a wake; wake pulses in POWER_UP
        for (int i = 0; i < 20; i++) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < 40; i++) cyc(1, 0, 0);
        idle(10);

        // Randomized segments with varied request densities
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 3))
                0: s_pct = 0;
                1: s_pct = 10;
                2: s_pct = 60;
                default: s_pct = 100;
            endcase
            case ($urandom_range(0, 3))
                0: w_pct = 0;
                1: w_pct = 5;
                2: w_pct = 40;
                default: w_pct = 100;
            endcase
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++)
                cyc(($urandom_range(0, 99) < s_pct) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < w_pct) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        idle(3);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d actual=%0d pending required=0", k, q[k].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_sequencer.md
# power_sequencer

Power-domain sequencer that generates the `power_en`, `iso_en`, `save` and `restore` controls for one switchable domain. It sits directly upstream of the power state monitor and drives the same four signals that the monitor checks. The sequencer accepts sleep/wake requests from the system power manager. It sequences isolate → save → power-off and power-up → restore → de-isolate, with programmable phase lengths and one-cycle acknowledge pulses.

## Interface
Parameters:
- `ISO_CYCLES`, default 2: cycles in ISOLATE before save starts. Legal range 1..15.
- `SAVE_CYCLES`, default 2: cycles `save` is held high. Legal range 1..15.
- `PWRUP_CYCLES`, default 4: settle cycles after `power_en` rises, before restore. Legal range 1..8, which keeps `restore` within 10 cycles of `power_en` rising.
- `RESTORE_CYCLES`, default 2: cycles `restore` is held high. Legal range 1..15.

Ports (the single clock is `clk`; reset is synchronous and active-high, named `rst`):
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sleep_req`  in  1  level; request power-down
- `wake_req`  in  1  level; request power-up, or abort a power-down in progress
- `power_en`  out  1  domain power switch enable
- `iso_en`  out  1  isolation clamp enable
- `save`  out  1  retention save strobe (level)
- `restore`  out  1  retention restore strobe (level)
- `sleep_ack`  out  1  one-cycle pulse on entering OFF
- `wake_ack`  out  1  one-cycle pulse on returning to ACTIVE
- `state_o`  out  3  current state: ACTIVE=0, ISOLATE=1, SAVE=2, OFF=3, POWER_UP=4, RESTORE=5
- `busy`  out  1  high in any state other than ACTIVE or OFF

## Operation
- The FSM is Moore. All outputs are registered and decoded from the next state, so they change on the same edge as `state_o`.
- Output levels per state (`power_en`/`iso_en`/`save`/`restore`):
  - ACTIVE: 1/0/0/0
  - ISOLATE: 1/1/0/0
  - SAVE: 1/1/1/0
  - OFF: 0/1/0/0
  - POWER_UP: 1/1/0/0
  - RESTORE: 1/1/0/1
- One 4-bit down-counter serves all timed phases. It is loaded with `<PARAM>-1` on state entry, and the phase exits on the edge where the counter is 0.
- Transitions:
  - ACTIVE: `sleep_req && !wake_req` → ISOLATE.
  - ISOLATE: when count expires → SAVE.
  - SAVE: when count expires → OFF.
  - OFF: `wake_req` → POWER_UP.
  - POWER_UP: when count expires → RESTORE.
  - RESTORE: when count expires → ACTIVE.
- Abort: `wake_req` sampled high in ISOLATE or SAVE → ACTIVE on the next edge, with `wake_ack` pulsed.
  - Power was never removed, so no restore is performed.
  - Abort takes priority over a count expiry on the same edge.
- Ignored inputs:
  - `sleep_req` is ignored outside ACTIVE.
  - `wake_req` is ignored in POWER_UP and RESTORE (power-up completes regardless).
  - `wake_req` in ACTIVE has no effect.
- `sleep_ack` is high exactly on the first cycle of OFF.
- `wake_ack` is high exactly on the first cycle of ACTIVE after RESTORE or after an abort.
- Guaranteed invariants:
  - `iso_en` is high whenever `power_en` is low.
  - `save` is high on the cycle immediately before `power_en` falls.
  - `iso_en` rises at least one cycle before `save`, and falls on the same edge that `restore` falls.

## Timing
- Reset (`rst` high at an edge) forces the following on that edge, regardless of current state, including mid-sequence or while OFF:
  - state ACTIVE, counter 0;
  - `power_en`=1, `iso_en`=0, `save`=0, `restore`=0;
  - `sleep_ack`=0, `wake_ack`=0, `busy`=0, `state_o`=0.
- Sleep sequence, default parameters, with `sleep_req` sampled at edge E:
  - `iso_en`=1 from E.
  - `save`=1 from E+2 to E+4.
  - `power_en`=0, `save`=0 and `sleep_ack`=1 at E+4.
  - General sleep latency: ISO_CYCLES+SAVE_CYCLES edges.
- Wake sequence, defaults, with `wake_req` sampled in OFF at edge W:
  - `power_en`=1 at W.
  - `restore`=1 from W+4 to W+6.
  - At W+6: `iso_en`=0, `restore`=0, `wake_ack`=1.
  - General wake latency: PWRUP_CYCLES+RESTORE_CYCLES edges.
- Simultaneous `sleep_req` and `wake_req` in ACTIVE: stay in ACTIVE, no acks.
- Requests are levels. If `sleep_req` is still high at the `wake_ack` edge, a new sleep starts on the next edge.

## Test plan
- **Reset then idle:** `rst`=1 for 2 cycles, then 0. All outputs equal their reset values, and `state_o`=0 for 20 cycles with no requests.
- **Full sleep/wake, defaults:**
  - Pulse `sleep_req` at edge 10: `iso_en` rises @10, `save` high @12–13, `power_en` falls with `sleep_ack` @14.
  - Pulse `wake_req` @30: `power_en` rises @30, `restore` high @34–35, `wake_ack` with `iso_en`=0 @36.
  - The power state monitor, bound to the outputs, reports no errors.
- **Abort:**
  - `wake_req` at the first SAVE cycle → ACTIVE next edge; `save`=0, `iso_en`=0, `wake_ack`=1, `power_en` never low.
  - Repeat with `wake_req` on the final SAVE count edge: result is still ACTIVE, never OFF.
- **Reset mid-sequence:** assert `rst` in OFF and again in RESTORE. The next edge gives `power_en`=1, `iso_en`=0, `restore`=0, `state_o`=0.
- **Parameter sweep:**
  - ISO=1, SAVE=15, PWRUP=8, RESTORE=1: phase lengths match exactly.
  - `restore` is sampled high within 10 cycles of `power_en` rising.
- **Request corners:**
  - Both requests high in ACTIVE: no transition.
  - `sleep_req` held high through a wake: new ISOLATE begins on the edge after `wake_ack`.
  - `wake_req` pulsed during POWER_UP: timing unchanged.
